// File: rtl/i3c_tgt_pkg.sv
// Shared definitions for the I3C target-side HDR receivers.
// Holds the DDR command-receiver state encoding and frame constants.
package i3c_tgt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_PRE,
      ST_DATA,
      ST_PAR,
      ST_CHECK
   } ddr_cmd_state_e;

   localparam logic [1:0] HDR_DDR_CMD_PREAMBLE = 2'b01;
   localparam logic [6:0] I3C_BCAST_ADDR       = 7'h7E;
   localparam int         HDR_DDR_FRAME_BITS   = 20;

endpackage

// File: rtl/ddr_parity_calc.sv
// HDR-DDR word parity: P1 covers odd data bits, P0 covers even data bits
// and is seeded with 1 so an all-zero word never yields all-zero parity.
module ddr_parity_calc (
   input  logic [15:0] word,
   output logic        par_p1,
   output logic        par_p0
);

   logic [7:0] odd_bits;
   logic [7:0] even_bits;

   for (genvar gi = 0; gi < 8; gi++) begin : g_split
      assign odd_bits[gi]  = word[2*gi+1];
      assign even_bits[gi] = word[2*gi];
   end

   assign par_p1 = ^odd_bits;
   assign par_p0 = ~(^even_bits);

endmodule

// File: rtl/hdr_ddr_cmd_rx_tgt.sv
// HDR-DDR command word receiver: captures PRE/D15..D0/P1/P0, decodes, checks.
// Define HDR_EXIT_DET_EN to add HDR-exit pattern detection (o_hdr_exit).
module hdr_ddr_cmd_rx_tgt
   import i3c_tgt_pkg::*;
#(
   parameter logic [1:0] CMD_PREAMBLE = HDR_DDR_CMD_PREAMBLE,
   parameter logic [6:0] BCAST_ADDR   = I3C_BCAST_ADDR
) (
   input  logic       i_sys_clk,
   input  logic       i_sys_rst,
   input  logic       i_engine_en,
   input  logic       i_sda,
   input  logic       i_scl_pos_edge,
   input  logic       i_scl_neg_edge,
   input  logic [6:0] i_dyn_addr,
`ifdef HDR_EXIT_DET_EN
   output logic       o_hdr_exit,
`endif
   output logic       o_cmd_valid,
   output logic       o_cmd_err,
   output logic       o_rnw,
   output logic [6:0] o_cmd_code,
   output logic [6:0] o_tgt_addr,
   output logic       o_bcast,
   output logic       o_busy
);

   localparam logic [4:0] LAST_DATA_IDX = 5'(HDR_DDR_FRAME_BITS - 3);
   localparam logic [4:0] LAST_IDX      = 5'(HDR_DDR_FRAME_BITS - 1);

   ddr_cmd_state_e state_reg, state_next;
   logic [HDR_DDR_FRAME_BITS-1:0] shift_reg, shift_next;
   logic [4:0] bit_cnt_reg, bit_cnt_next;
   logic       busy_reg, busy_next;
   logic       valid_reg, valid_next;
   logic       err_reg, err_next;
   logic       rnw_reg, rnw_next;
   logic [6:0] code_reg, code_next;
   logic [6:0] addr_reg, addr_next;
   logic       bcast_reg, bcast_next;

   logic        edge_any;
   logic        frame_done;
   logic        exit_hit;
   logic [15:0] frame_word;
   logic [6:0]  frame_addr;
   logic        calc_p1, calc_p0;
   logic        frame_bad;
   logic        frame_match;

   assign edge_any   = i_scl_pos_edge | i_scl_neg_edge;
   // Decode looks at the frame as it will be once P0 is shifted in.
   assign frame_word = shift_next[17:2];
   assign frame_addr = frame_word[7:1];

   ddr_parity_calc u_parity (
      .word   (frame_word),
      .par_p1 (calc_p1),
      .par_p0 (calc_p0)
   );

   assign frame_bad   = (shift_next[19:18] != CMD_PREAMBLE) |
                        (shift_next[1:0] != {calc_p1, calc_p0});
   assign frame_match = (frame_addr == i_dyn_addr) | (frame_addr == BCAST_ADDR);

`ifdef HDR_EXIT_DET_EN
   logic       sda_prev_reg;
   logic       scl_low_reg;
   logic [2:0] exit_cnt_reg, exit_cnt_next;
   logic       exit_reg;
   logic       sda_fall;

   assign sda_fall = sda_prev_reg & ~i_sda & scl_low_reg & ~edge_any;
   assign exit_hit = sda_fall & (exit_cnt_reg == 3'd3);

   always_comb begin
      exit_cnt_next = exit_cnt_reg;
      if (edge_any || exit_hit)
         exit_cnt_next = 3'd0;
      else if (sda_fall)
         exit_cnt_next = exit_cnt_reg + 3'd1;
   end

   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_rst) begin
         sda_prev_reg <= 1'b0;
         scl_low_reg  <= 1'b0;
         exit_cnt_reg <= 3'd0;
         exit_reg     <= 1'b0;
      end else begin
         sda_prev_reg <= i_sda;
         if (i_scl_neg_edge)
            scl_low_reg <= 1'b1;
         else if (i_scl_pos_edge)
            scl_low_reg <= 1'b0;
         exit_cnt_reg <= exit_cnt_next;
         exit_reg     <= exit_hit;
      end
   end

   assign o_hdr_exit = exit_reg;
`else
   assign exit_hit = 1'b0;
`endif

   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt_reg;
      frame_done   = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            if (i_engine_en) begin
               state_next   = ST_ARM;
               bit_cnt_next = 5'd0;
            end
         end
         ST_ARM: begin
            if (i_scl_pos_edge) begin
               shift_next   = {shift_reg[HDR_DDR_FRAME_BITS-2:0], i_sda};
               bit_cnt_next = 5'd1;
               state_next   = ST_PRE;
            end
         end
         ST_PRE: begin
            if (edge_any) begin
               shift_next   = {shift_reg[HDR_DDR_FRAME_BITS-2:0], i_sda};
               bit_cnt_next = bit_cnt_reg + 5'd1;
               state_next   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (edge_any) begin
               shift_next   = {shift_reg[HDR_DDR_FRAME_BITS-2:0], i_sda};
               bit_cnt_next = bit_cnt_reg + 5'd1;
               if (bit_cnt_reg == LAST_DATA_IDX)
                  state_next = ST_PAR;
            end
         end
         ST_PAR: begin
            if (edge_any) begin
               shift_next   = {shift_reg[HDR_DDR_FRAME_BITS-2:0], i_sda};
               bit_cnt_next = bit_cnt_reg + 5'd1;
               if (bit_cnt_reg == LAST_IDX) begin
                  bit_cnt_next = 5'd0;
                  state_next   = ST_CHECK;
                  frame_done   = 1'b1;
               end
            end
         end
         ST_CHECK: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
      if (exit_hit) begin
         state_next   = ST_IDLE;
         bit_cnt_next = 5'd0;
      end
   end

   // Result and decode registers load on the P0 edge so they are visible in CHECK.
   always_comb begin
      busy_next  = (state_next == ST_ARM) || (state_next == ST_PRE) ||
                   (state_next == ST_DATA) || (state_next == ST_PAR);
      valid_next = frame_done & ~frame_bad & frame_match;
      err_next   = frame_done & frame_bad;
      rnw_next   = rnw_reg;
      code_next  = code_reg;
      addr_next  = addr_reg;
      bcast_next = bcast_reg;
      if (frame_done) begin
         rnw_next   = frame_word[15];
         code_next  = frame_word[14:8];
         addr_next  = frame_addr;
         bcast_next = (frame_addr == BCAST_ADDR);
      end
   end

   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_rst) begin
         state_reg   <= ST_IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= 5'd0;
         busy_reg    <= 1'b0;
         valid_reg   <= 1'b0;
         err_reg     <= 1'b0;
         rnw_reg     <= 1'b0;
         code_reg    <= 7'd0;
         addr_reg    <= 7'd0;
         bcast_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         bit_cnt_reg <= bit_cnt_next;
         busy_reg    <= busy_next;
         valid_reg   <= valid_next;
         err_reg     <= err_next;
         rnw_reg     <= rnw_next;
         code_reg    <= code_next;
         addr_reg    <= addr_next;
         bcast_reg   <= bcast_next;
      end
   end

   assign o_cmd_valid = valid_reg;
   assign o_cmd_err   = err_reg;
   assign o_rnw       = rnw_reg;
   assign o_cmd_code  = code_reg;
   assign o_tgt_addr  = addr_reg;
   assign o_bcast     = bcast_reg;
   assign o_busy      = busy_reg;

endmodule
